watch_dp: RTL and testbench

- Timekeeping datapath of the watch; sits directly downstream of the watch control unit.
- Divides clk into a 100 Hz tick and keeps cascaded counters: centiseconds 0-99, seconds 0-59, minutes 0-59, hours 0-23.
- Consumes the control unit's single-cycle set pulses (hour/min/sec) and increments the selected field without carry.
- Drives the display/FND formatter.

---
 rtl/watch_dp.sv | 62 ++++++
 tb/tb_watch_dp.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/watch_dp.sv
// watch_dp: 100 Hz tick divider driving cascaded msec/sec/min/hour counters with set pulses
module watch_dp #(
    parameter int TICK_DIV  = 1_000_000,
    parameter int INIT_HOUR = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_hour,
    input  logic       i_min,
    input  logic       i_sec,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_tick
);
    localparam int DW = $clog2(TICK_DIV);

    logic [DW-1:0] div_cnt;
    logic          tick_en, ms_co, s_co, m_co;
    logic [7:0]    ms_sum;
    logic [6:0]    s_sum, m_sum;
    logic [5:0]    h_sum;
    logic [6:0]    ms_nxt;
    logic [5:0]    s_nxt, m_nxt;
    logic [4:0]    h_nxt;

    // carry chain: sum = cur + cin + set, one conditional subtract wraps it; sets never carry
    always_comb begin
        tick_en = div_cnt == DW'(TICK_DIV - 1);
        ms_co   = tick_en && o_msec == 7'd99;
        s_co    = ms_co && o_sec == 6'd59;
        m_co    = s_co && o_min == 6'd59;
        ms_sum  = {1'b0, o_msec} + {7'd0, tick_en};
        s_sum   = {1'b0, o_sec} + {6'd0, ms_co} + {6'd0, i_sec};
        m_sum   = {1'b0, o_min} + {6'd0, s_co} + {6'd0, i_min};
        h_sum   = {1'b0, o_hour} + {5'd0, m_co} + {5'd0, i_hour};
        ms_nxt  = ms_sum >= 8'd100 ? 7'(ms_sum - 8'd100) : ms_sum[6:0];
        s_nxt   = s_sum >= 7'd60 ? 6'(s_sum - 7'd60) : s_sum[5:0];
        m_nxt   = m_sum >= 7'd60 ? 6'(m_sum - 7'd60) : m_sum[5:0];
        h_nxt   = h_sum >= 6'd24 ? 5'(h_sum - 6'd24) : h_sum[4:0];
    end

    // divider and all fields update on one edge; o_tick is registered so it lines up with o_msec
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            o_msec  <= '0;
            o_sec   <= '0;
            o_min   <= '0;
            o_hour  <= 5'(INIT_HOUR);
            o_tick  <= 1'b0;
        end else begin
            div_cnt <= tick_en ? '0 : div_cnt + DW'(1);
            o_msec  <= ms_nxt;
            o_sec   <= s_nxt;
            o_min   <= m_nxt;
            o_hour  <= h_nxt;
            o_tick  <= tick_en;
        end
    end
endmodule

// File: tb/tb_watch_dp.sv
// tb_watch_dp: table-driven scoreboard bench for watch_dp with TICK_DIV=4, INIT_HOUR=12
module tb_watch_dp;
    logic       clk = 1'b0, rst = 1'b0, i_hour = 1'b0, i_min = 1'b0, i_sec = 1'b0;
    logic [6:0] o_msec;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;
    logic       o_tick;

    watch_dp #(.TICK_DIV(4), .INIT_HOUR(12)) dut (
        .clk(clk), .rst(rst), .i_hour(i_hour), .i_min(i_min), .i_sec(i_sec),
        .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_tick(o_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] ms;
        logic [5:0] s;
        logic [5:0] m;
        logic [4:0] h;
        logic       t;
    } out_t;

    typedef struct {
        bit   r;
        int   n;
        bit   h;
        bit   m;
        bit   s;
        out_t e;
    } vec_t;

    vec_t vt[$];
    out_t sb[$];
    int   nvec = 0, nerr = 0;

    function automatic out_t ex(int ms, int s, int m, int h, bit t);
        out_t o;
        o.ms = 7'(ms);
        o.s  = 6'(s);
        o.m  = 6'(m);
        o.h  = 5'(h);
        o.t  = t;
        return o;
    endfunction

    function automatic vec_t mk(bit r, int n, bit h, bit m, bit s, int ms, int sc, int mn, int hr, bit t);
        vec_t v;
        v.r = r;
        v.n = n;
        v.h = h;
        v.m = m;
        v.s = s;
        v.e = ex(ms, sc, mn, hr, t);
        return v;
    endfunction

    task automatic check(string tag);
        out_t act, exp;
        act = {o_msec, o_sec, o_min, o_hour, o_tick};
        nvec++;
        if (sb.size() == 0) begin
            nerr++;
            $display("FAIL %s: no expected entry in scoreboard", tag);
            return;
        end
        exp = sb.pop_front();
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got ms=%0d s=%0d m=%0d h=%0d t=%0d, want ms=%0d s=%0d m=%0d h=%0d t=%0d",
                     tag, act.ms, act.s, act.m, act.h, act.t, exp.ms, exp.s, exp.m, exp.h, exp.t);
        end
    endtask

    task automatic run(bit h, bit m, bit s, int n);
        for (int k = 0; k < n; k++) begin
            i_hour = h;
            i_min  = m;
            i_sec  = s;
            @(posedge clk);
            @(negedge clk);
        end
        i_hour = 1'b0;
        i_min  = 1'b0;
        i_sec  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // tick cadence and single set pulses
        vt.push_back(mk(1, 4, 0, 0, 0, 1, 0, 0, 12, 1));
        vt.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 12, 0));
        vt.push_back(mk(0, 3, 0, 0, 0, 2, 0, 0, 12, 1));
        vt.push_back(mk(0, 1, 0, 0, 1, 2, 1, 0, 12, 0));
        vt.push_back(mk(0, 1, 0, 1, 0, 2, 1, 1, 12, 0));
        vt.push_back(mk(0, 1, 1, 0, 0, 2, 1, 1, 13, 0));
        vt.push_back(mk(0, 1, 0, 0, 0, 3, 1, 1, 13, 1));
        // msec->sec and sec->min carries
        vt.push_back(mk(1, 396, 0, 0, 0, 99, 0, 0, 12, 1));
        vt.push_back(mk(0, 4, 0, 0, 0, 0, 1, 0, 12, 1));
        vt.push_back(mk(0, 23596, 0, 0, 0, 99, 59, 0, 12, 1));
        vt.push_back(mk(0, 4, 0, 0, 0, 0, 0, 1, 12, 1));
        // minute set wraps 59->0 without touching hour
        vt.push_back(mk(1, 59, 0, 1, 0, 14, 0, 59, 12, 0));
        vt.push_back(mk(0, 10, 0, 0, 1, 17, 10, 59, 12, 0));
        vt.push_back(mk(0, 1, 0, 1, 0, 17, 10, 0, 12, 0));
        vt.push_back(mk(0, 2, 0, 0, 0, 18, 10, 0, 12, 1));
        // preload 23:59:59.99 then full rollover
        vt.push_back(mk(1, 11, 1, 1, 1, 2, 11, 11, 23, 0));
        vt.push_back(mk(0, 48, 0, 1, 1, 14, 59, 59, 23, 0));
        vt.push_back(mk(0, 337, 0, 0, 0, 99, 59, 59, 23, 1));
        vt.push_back(mk(0, 4, 0, 0, 0, 0, 0, 0, 0, 1));
        // set coinciding with natural carry
        vt.push_back(mk(1, 59, 0, 0, 1, 14, 59, 0, 12, 0));
        vt.push_back(mk(0, 340, 0, 0, 0, 99, 59, 0, 12, 0));
        vt.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 12, 1));
        vt.push_back(mk(0, 57, 0, 0, 1, 14, 58, 1, 12, 0));
        vt.push_back(mk(0, 342, 0, 0, 0, 99, 58, 1, 12, 0));
        vt.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 12, 1));

        #2 rst = 1'b1;
        #1;
        sb.push_back(ex(0, 0, 0, 12, 0));
        check("reset");
        @(negedge clk);

        foreach (vt[i]) begin
            if (vt[i].r) do_reset();
            sb.push_back(vt[i].e);
            run(vt[i].h, vt[i].m, vt[i].s, vt[i].n);
            check($sformatf("vec%0d", i));
        end

        // async reset between edges while i_hour is high
        @(posedge clk);
        #3;
        i_hour = 1'b1;
        rst    = 1'b1;
        #1;
        sb.push_back(ex(0, 0, 0, 12, 0));
        check("async_rst");
        @(negedge clk);
        @(negedge clk);
        sb.push_back(ex(0, 0, 0, 12, 0));
        check("rst_hold");
        rst    = 1'b0;
        i_hour = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sb.push_back(k == 4 ? ex(1, 0, 0, 12, 1) : ex(0, 0, 0, 12, 0));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("post_rst%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
